// File: rtl/axi4.sv
// Shared AXI4 definitions: response codes and small helpers used by bus masters and slaves.
package axi4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int unsigned RESP_WIDTH = 2;
    localparam int unsigned PROT_WIDTH = 3;

    // Anything other than a plain OKAY is reported upstream as an error.
    function automatic logic resp_is_error(input logic [RESP_WIDTH-1:0] resp);
        return resp != OKAY;
    endfunction

endpackage

// File: rtl/axi.sv
// AXI4-Lite style bundle with master and slave views.
interface axi #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;

    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi_requester.sv
// Single-outstanding AXI requester: converts one valid/ready request into an AW/W/B or AR/R
// exchange and presents the completion on a valid/ready response port.
module axi_requester
    import axi4::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    axi.master                      bus
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  arvalid_q;
    logic                  bready_q;
    logic                  rready_q;

    logic aw_done;
    logic w_done;

    // A channel counts as finished once its valid is gone or is being accepted right now.
    assign aw_done = !awvalid_q || bus.awready;
    assign w_done  = !wvalid_q || bus.wready;

    // Held low during reset so nothing can be accepted in the cycle reset is sampled.
    assign req_ready = (state == IDLE) && !reset;

    assign bus.awvalid = awvalid_q;
    assign bus.awaddr  = addr_q;
    assign bus.awprot  = '0;
    assign bus.wvalid  = wvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.bready  = bready_q;
    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = addr_q;
    assign bus.arprot  = '0;
    assign bus.rready  = rready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (req_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= READ;
                        end
                    end
                end

                WRITE: begin
                    if (aw_done && w_done) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state     <= WRESP;
                    end else begin
                        if (awvalid_q && bus.awready) awvalid_q <= 1'b0;
                        if (wvalid_q && bus.wready)   wvalid_q  <= 1'b0;
                    end
                end

                WRESP: begin
                    if (bus.bvalid) begin
                        bready_q  <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_error <= resp_is_error(bus.bresp);
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                READ: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RDATA;
                    end
                end

                RDATA: begin
                    if (bus.rvalid) begin
                        rready_q  <= 1'b0;
                        rsp_rdata <= bus.rdata;
                        rsp_error <= resp_is_error(bus.rresp);
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_requester.sv
// Bench for axi_requester: directed requests against a small AXI memory slave with
// per-channel wait states, scoreboard-checked completions and channel stability monitors.
module tb_axi_requester;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          slv_reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;

    axi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = axi4::OKAY;
    logic [1:0]  rresp_cfg = axi4::OKAY;
    logic [31:0] mem [0:63];
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, r_pend;
    logic [31:0] aw_addr_s, w_data_s, r_addr_s;
    logic [3:0]  w_strb_s;
    int          b_hs_cnt = 0, aw_hs_cnt = 0;
    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    assign bus.awready = bus.awvalid && !aw_got && (aw_cnt >= aw_delay);
    assign bus.wready  = bus.wvalid && !w_got && (w_cnt >= w_delay);
    assign bus.arready = bus.arvalid && (ar_cnt >= ar_delay);
    assign aw_hs   = bus.awvalid && bus.awready;
    assign w_hs    = bus.wvalid && bus.wready;
    assign ar_hs   = bus.arvalid && bus.arready;
    assign wr_addr = aw_hs ? bus.awaddr : aw_addr_s;
    assign wr_data = w_hs ? bus.wdata : w_data_s;
    assign wr_strb = w_hs ? bus.wstrb : w_strb_s;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (slv_reset) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0; r_addr_s <= '0;
            bus.bvalid <= 1'b0; bus.bresp <= '0;
            bus.rvalid <= 1'b0; bus.rresp <= '0; bus.rdata <= '0;
        end else begin
            aw_cnt <= (bus.awvalid && !aw_hs) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.wvalid && !w_hs) ? w_cnt + 1 : 0;
            ar_cnt <= (bus.arvalid && !ar_hs) ? ar_cnt + 1 : 0;
            if (aw_hs) begin
                aw_got    <= 1'b1;
                aw_addr_s <= bus.awaddr;
                aw_hs_cnt <= aw_hs_cnt + 1;
            end
            if (w_hs) begin
                w_got    <= 1'b1;
                w_data_s <= bus.wdata;
                w_strb_s <= bus.wstrb;
            end
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
                b_hs_cnt   <= b_hs_cnt + 1;
            end
            if ((aw_hs || aw_got) && (w_hs || w_got)) begin
                if (bresp_cfg == axi4::OKAY) begin
                    for (int b = 0; b < 4; b++)
                        if (wr_strb[b]) mem[wr_addr[7:2]][8*b +: 8] <= wr_data[8*b +: 8];
                end
                bus.bvalid <= 1'b1;
                bus.bresp  <= bresp_cfg;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            if (ar_hs) begin
                if (r_delay == 0) begin
                    bus.rvalid <= 1'b1;
                    bus.rdata  <= mem[bus.araddr[7:2]];
                    bus.rresp  <= rresp_cfg;
                end else begin
                    r_pend   <= 1'b1;
                    r_cnt    <= 1;
                    r_addr_s <= bus.araddr;
                end
            end else if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    bus.rvalid <= 1'b1;
                    bus.rdata  <= mem[r_addr_s[7:2]];
                    bus.rresp  <= rresp_cfg;
                    r_pend     <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    // ---------------- scoreboard / monitors ----------------
    exp_t        exp_q[$];
    exp_t        e;
    int          cyc = 0, hs_cyc = 0, last_lat = 0;
    int          req_cnt = 0, rsp_cnt = 0;
    logic        seen_w_first = 1'b0, seen_stale_rvalid = 1'b0;
    logic        p_reset = 1'b1;
    logic        p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready;
    logic        p_rsp_valid = 1'b0, p_rsp_ready, p_rsp_error;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rsp_rdata;
    logic [3:0]  p_wstrb;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            rsp_cnt = req_cnt;
        end else begin
            if (!p_reset) begin
                if (p_awvalid && !p_awready)
                    chk("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, p_awaddr});
                if (p_wvalid && !p_wready)
                    chk("w_hold", {bus.wvalid, bus.wdata, bus.wstrb}, {1'b1, p_wdata, p_wstrb});
                if (p_arvalid && !p_arready)
                    chk("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, p_araddr});
                if (p_rsp_valid && !p_rsp_ready)
                    chk("rsp_hold", {rsp_valid, rsp_error, rsp_rdata},
                        {1'b1, p_rsp_error, p_rsp_rdata});
            end
            if (bus.awvalid || bus.arvalid) chk("prot_zero", {bus.awprot, bus.arprot}, 6'd0);
            if (req_valid && req_ready) begin
                chk("req_after_rsp", rsp_cnt, req_cnt);
                req_cnt++;
                hs_cyc = cyc;
            end
            if (rsp_valid && !p_rsp_valid) last_lat = cyc - hs_cyc;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_error", rsp_error, e.err);
                end
                rsp_cnt++;
            end
            if (bus.awvalid && !bus.wvalid) seen_w_first = 1'b1;
            if (bus.rvalid && !bus.rready) seen_stale_rvalid = 1'b1;
        end
        p_reset     = reset;
        p_awvalid   = bus.awvalid; p_awready = bus.awready; p_awaddr = bus.awaddr;
        p_wvalid    = bus.wvalid;  p_wready  = bus.wready;
        p_wdata     = bus.wdata;   p_wstrb   = bus.wstrb;
        p_arvalid   = bus.arvalid; p_arready = bus.arready; p_araddr = bus.araddr;
        p_rsp_valid = rsp_valid;   p_rsp_ready = rsp_ready;
        p_rsp_error = rsp_error;   p_rsp_rdata = rsp_rdata;
    end

    // ---------------- stimulus ----------------
    task automatic wait_req_ready(input string name);
        bit got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                break;
            end
        end
        chk(name, got, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [31:0] exp_rdata,
                         input logic exp_err);
        exp_q.push_back('{exp_rdata, exp_err});
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        req_valid = 1'b1;
        wait_req_ready("req_accept_timeout");
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && rsp_cnt == req_cnt) begin
                got = 1;
                break;
            end
        end
        chk("rsp_timeout", got, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, r0, a0;
        bit got;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready,
                           rsp_valid, rsp_error}, 7'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        slv_reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;

        // Zero-wait write then read-back
        issue(1'b1, 32'h10, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        wait_done();
        chk("wr_latency", last_lat, 3);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        wait_done();
        chk("rd_latency", last_lat, 3);

        // W accepted three cycles ahead of AW, partial strobe
        aw_delay = 3;
        seen_w_first = 1'b0;
        b0 = b_hs_cnt;
        r0 = rsp_cnt;
        issue(1'b1, 32'h20, 32'hA5A5_0F0F, 4'h3, 32'h0, 1'b0);
        wait_done();
        chk("w_before_aw", seen_w_first, 1'b1);
        chk("b_handshakes", b_hs_cnt - b0, 1);
        chk("completions", rsp_cnt - r0, 1);
        aw_delay = 0;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h0000_0F0F, 1'b0);
        wait_done();

        // Slow AR and a stalled response port
        issue(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        wait_done();
        ar_delay = 5;
        rsp_ready = 1'b0;
        issue(1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        chk("rsp_valid_timeout", got, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("stall_rsp_valid", rsp_valid, 1'b1);
            chk("stall_rdata", rsp_rdata, 32'hCAFE_F00D);
            chk("stall_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_done();
        ar_delay = 0;

        // Error responses
        bresp_cfg = axi4::SLVERR;
        issue(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
        wait_done();
        bresp_cfg = axi4::OKAY;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        wait_done();
        rresp_cfg = axi4::DECERR;
        issue(1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
        wait_done();
        rresp_cfg = axi4::OKAY;
        issue(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0);
        wait_done();

        // Reset while waiting for read data; the late rvalid must be ignored
        r_delay = 6;
        seen_stale_rvalid = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rready) begin
                got = 1;
                break;
            end
        end
        chk("reach_rdata", got, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready,
                              rsp_valid}, 6'd0);
        chk("midrst_req_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", req_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_quiet", {bus.rready, bus.bready, rsp_valid}, 3'd0);
        end
        chk("stale_rvalid_ignored", seen_stale_rvalid, 1'b1);
        @(posedge clk);
        #1;
        slv_reset = 1'b1;
        r_delay = 0;
        @(posedge clk);
        #1;
        slv_reset = 1'b0;

        // Back-to-back writes with req_valid held high
        a0 = aw_hs_cnt;
        exp_q.push_back('{32'h0, 1'b0});
        exp_q.push_back('{32'h0, 1'b0});
        req_write = 1'b1;
        req_addr  = 32'h50;
        req_wdata = 32'h1111_2222;
        req_wstrb = 4'hF;
        req_valid = 1'b1;
        wait_req_ready("b2b_first_timeout");
        req_addr  = 32'h54;
        req_wdata = 32'h3333_4444;
        wait_req_ready("b2b_second_timeout");
        req_valid = 1'b0;
        wait_done();
        chk("b2b_aw_count", aw_hs_cnt - a0, 2);
        issue(1'b0, 32'h50, 32'h0, 4'h0, 32'h1111_2222, 1'b0);
        wait_done();
        issue(1'b0, 32'h54, 32'h0, 4'h0, 32'h3333_4444, 1'b0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
